// File: rtl/mul_hilo.sv
// HI/LO multiply unit that drives an external signed multiplier and updates HI/LO LAT cycles later.
// Define MUL_HILO_MADD_EN to enable the accumulating ops MADD/MADDU.
module mul_hilo #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpMthi  = 3'b010;
  localparam logic [2:0] OpMtlo  = 3'b011;
`ifdef MUL_HILO_MADD_EN
  localparam logic [2:0] OpMadd  = 3'b100;
  localparam logic [2:0] OpMaddu = 3'b101;
`endif
  localparam logic [3:0] CntInit = 4'(LAT - 1);

  typedef enum logic {StIdle, StCalc} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        uns_q, uns_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        is_mul_op;
  logic [31:0] corr;
  logic [63:0] prod;
  logic [63:0] result;

`ifdef MUL_HILO_MADD_EN
  logic acc_q, acc_d;

  assign is_mul_op = (op == OpMult) || (op == OpMultu) || (op == OpMadd) || (op == OpMaddu);
`else
  assign is_mul_op = (op == OpMult) || (op == OpMultu);
`endif

  // Turn the signed product into the unsigned one; only the low 32 bits of the
  // correction survive the shift into the upper word.
  assign corr = (mul_a_q[31] ? mul_b_q : 32'h0) + (mul_b_q[31] ? mul_a_q : 32'h0);
  assign prod = uns_q ? (mul_z + {corr, 32'h0}) : mul_z;

`ifdef MUL_HILO_MADD_EN
  assign result = acc_q ? ({hi_q, lo_q} + prod) : prod;
`else
  assign result = prod;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    uns_d   = uns_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MUL_HILO_MADD_EN
    acc_d   = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_mul_op) begin
            state_d = StCalc;
            cnt_d   = CntInit;
            uns_d   = op[0];
            mul_a_d = a;
            mul_b_d = b;
`ifdef MUL_HILO_MADD_EN
            acc_d   = op[2];
`endif
          end else if (op == OpMthi) begin
            hi_d   = a;
            done_d = 1'b1;
          end else if (op == OpMtlo) begin
            lo_d   = a;
            done_d = 1'b1;
          end
        end
      end
      StCalc: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          {hi_d, lo_d} = result;
          state_d      = StIdle;
          done_d       = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      uns_q   <= 1'b0;
      mul_a_q <= 32'h0;
      mul_b_q <= 32'h0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      done_q  <= 1'b0;
`ifdef MUL_HILO_MADD_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      uns_q   <= uns_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MUL_HILO_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign busy  = (state_q == StCalc);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mul_hilo.sv
// Self-checking bench for mul_hilo: directed corner cases plus random ops against a 64-bit model.
module tb_mul_hilo;

  localparam int unsigned Lat = 2;
  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpMthi  = 3'b010;
  localparam logic [2:0] OpMtlo  = 3'b011;
  localparam logic [2:0] OpMadd  = 3'b100;
  localparam logic [2:0] OpMaddu = 3'b101;
`ifdef MUL_HILO_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_z;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic signed [63:0] ma_ext, mb_ext;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] ref_hi, ref_lo, last_a, last_b;

  mul_hilo #(.LAT(Lat)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_z (mul_z),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Downstream combinational signed multiplier.
  assign ma_ext = $signed(mul_a);
  assign mb_ext = $signed(mul_b);
  assign mul_z  = ma_ext * mb_ext;

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, required finish before 400000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_product(input bit uns, input logic [31:0] x,
                                              input logic [31:0] y);
    logic signed [63:0] sx, sy;
    if (uns) return {32'h0, x} * {32'h0, y};
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_hi"}, {32'h0, hi}, {32'h0, ref_hi});
    check({tag, "_lo"}, {32'h0, lo}, {32'h0, ref_lo});
    check({tag, "_mul_a"}, {32'h0, mul_a}, {32'h0, last_a});
    check({tag, "_mul_b"}, {32'h0, mul_b}, {32'h0, last_b});
    check({tag, "_busy"}, {63'h0, busy}, 64'h0);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int nbusy;
    bit is_mul;
    is_mul = (o == OpMult) || (o == OpMultu) || (MaddEn && (o == OpMadd || o == OpMaddu));
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    if (is_mul) begin
      p = ref_product(o[0], x, y);
      if (o[2]) p = p + {ref_hi, ref_lo};
      ref_hi = p[63:32];
      ref_lo = p[31:0];
      last_a = x;
      last_b = y;
      nbusy  = 0;
      for (int i = 0; i < int'(Lat) + 4; i++) begin
        if (done) break;
        if (busy) nbusy++;
        @(negedge clk);
      end
      check("mul_done", {63'h0, done}, 64'h1);
      check("mul_busy_cycles", 64'(nbusy), 64'(Lat));
    end else if (o == OpMthi || o == OpMtlo) begin
      if (o == OpMthi) ref_hi = x;
      else ref_lo = x;
      check("mt_done", {63'h0, done}, 64'h1);
    end else begin
      check("noop_done", {63'h0, done}, 64'h0);
    end
    check_state("op");
    @(negedge clk);
    check("done_single", {63'h0, done}, 64'h0);
    check_state("hold");
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 3'b0; a = 32'h0; b = 32'h0;
    ref_hi = 32'h0; ref_lo = 32'h0; last_a = 32'h0; last_b = 32'h0;
    repeat (2) @(negedge clk);
    check_state("reset");
    check("reset_done", {63'h0, done}, 64'h0);
    rst = 1'b1;

    do_op(OpMult, 32'hFFFF_FFFF, 32'h0000_0002);
    check("mult_hi_const", {32'h0, hi}, 64'hFFFF_FFFF);
    check("mult_lo_const", {32'h0, lo}, 64'hFFFF_FFFE);
    do_op(OpMultu, 32'hFFFF_FFFF, 32'h0000_0002);
    check("multu_hi_const", {32'h0, hi}, 64'h1);
    check("multu_lo_const", {32'h0, lo}, 64'hFFFF_FFFE);
    do_op(OpMthi, 32'h1234_5678, 32'h0);
    do_op(OpMtlo, 32'h9ABC_DEF0, 32'h0);
    check("mt_pair", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

    do_op(OpMthi, 32'h0, 32'h0);
    do_op(OpMtlo, 32'hFFFF_FFFF, 32'h0);
    do_op(OpMaddu, 32'h1, 32'h1);
    if (MaddEn) check("maddu_const", {hi, lo}, 64'h0000_0001_0000_0000);
    else check("maddu_off_const", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    do_op(OpMadd, 32'h8000_0000, 32'h7FFF_FFFF);
    do_op(3'b110, 32'hDEAD_BEEF, 32'h1);
    do_op(3'b111, 32'hCAFE_F00D, 32'h2);
    do_op(OpMultu, 32'h8000_0000, 32'h8000_0000);
    do_op(OpMult, 32'h8000_0000, 32'h8000_0000);

    // A request arriving while busy must be dropped, not queued.
    @(negedge clk);
    start = 1'b1; op = OpMult; a = 32'h0000_1234; b = 32'hFFFF_FFF0;
    @(negedge clk);
    op = OpMtlo; a = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    begin
      logic [63:0] p;
      p = ref_product(1'b0, 32'h0000_1234, 32'hFFFF_FFF0);
      ref_hi = p[63:32]; ref_lo = p[31:0];
      last_a = 32'h0000_1234; last_b = 32'hFFFF_FFF0;
    end
    for (int i = 0; i < int'(Lat) + 4; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("busy_drop_done", {63'h0, done}, 64'h1);
    check_state("busy_drop");
    @(negedge clk);
    check("busy_drop_single", {63'h0, done}, 64'h0);
    check("busy_drop_lo", {32'h0, lo}, {32'h0, ref_lo});

    for (int k = 0; k < 40; k++) begin
      logic [31:0] rx, ry;
      rx = (k % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
      ry = (k % 8 == 1) ? 32'h8000_0000 : $urandom;
      do_op(3'($urandom_range(0, 7)), rx, ry);
    end

    // Reset in the middle of a multiply aborts it.
    @(negedge clk);
    start = 1'b1; op = OpMult; a = 32'h7777_7777; b = 32'h3;
    @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b0;
    #1;
    ref_hi = 32'h0; ref_lo = 32'h0; last_a = 32'h0; last_b = 32'h0;
    check_state("mid_reset");
    check("mid_reset_done", {63'h0, done}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < int'(Lat) + 3; i++) begin
      @(negedge clk);
      check("post_reset_done", {63'h0, done}, 64'h0);
      check("post_reset_busy", {63'h0, busy}, 64'h0);
    end
    check_state("post_reset");

    do_op(OpMultu, 32'hABCD_0123, 32'hFEDC_BA98);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_hilo.md
MUL_HILO -- requirements
Module: mul_hilo

Interface
REQ-001 Parameter LAT, default 2, cycles from an accepted multiply start to the HI/LO update; legal range 1..15.
REQ-002 Clock and reset are decided: one clock, clk; reset rst is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request strobe, sampled on the rising edge.
REQ-006 op  input  3  000 MULT, 001 MULTU, 010 MTHI, 011 MTLO, 100 MADD, 101 MADDU; other codes are no-ops.
REQ-007 a  input  32  rs operand.
REQ-008 b  input  32  rt operand.
REQ-009 mul_a  output  32  registered operand a, driven to the downstream combinational signed multiplier.
REQ-010 mul_b  output  32  registered operand b, driven to the same multiplier.
REQ-011 mul_z  input  64  signed product returned by that multiplier.
REQ-012 busy  output  1  high while a multiply is in flight.
REQ-013 done  output  1  one-cycle pulse after any HI/LO write.
REQ-014 hi  output  32  HI register.
REQ-015 lo  output  32  LO register.

Function
REQ-016 States SHALL be IDLE and CALC; busy SHALL equal (state==CALC).
REQ-017 In IDLE, a rising edge with start=1 and op in {MULT, MULTU, MADD, MADDU} SHALL register a, b and op, load cnt=LAT-1 and enter CALC.
REQ-018 In IDLE, a rising edge with start=1 and op=MTHI SHALL write hi<=a, and with op=MTLO SHALL write lo<=a, staying in IDLE with done=1 the next cycle.
REQ-019 In CALC, each rising edge with cnt!=0 SHALL decrement cnt.
REQ-020 In CALC, the rising edge with cnt==0 SHALL write {hi,lo} from the result (REQ-021..023), return to IDLE and assert done for one cycle.
REQ-021 The signed result P for MULT/MADD SHALL be mul_z.
REQ-022 The unsigned result P for MULTU/MADDU SHALL be mul_z + (((a31?b:0)+(b31?a:0))<<32) mod 2^64, using registered operands.
REQ-023 For MADD/MADDU the write SHALL be {hi,lo}+P mod 2^64, and for MULT/MULTU it SHALL be P.
REQ-024 The HI/LO update SHALL occur at the LAT-th rising edge after acceptance.
REQ-025 start SHALL be ignored while in CALC (no queueing, no error).
REQ-026 mul_a and mul_b SHALL hold their last accepted values in IDLE.
REQ-027 hi and lo SHALL change only on reset or on the writes defined in REQ-018 and REQ-020.
REQ-028 done SHALL be low except in the single cycle after a write.

Reset
REQ-029 rst=0 SHALL asynchronously force: state=IDLE, cnt=0, hi=0, lo=0, mul_a=0, mul_b=0, busy=0, done=0.
REQ-030 Reset asserted mid-CALC SHALL abort the operation with no HI/LO write and no done pulse after release.

Configuration
REQ-031 The macro MUL_HILO_MADD_EN SHALL control support for the accumulating ops.
REQ-032 With MUL_HILO_MADD_EN defined, MADD and MADDU SHALL behave per REQ-023.
REQ-033 Without MUL_HILO_MADD_EN, op codes 100 and 101 SHALL be no-ops: no state change, no done pulse, and no accumulator adder logic.

Verification
REQ-034 MULT with a=0xFFFFFFFF, b=0x00000002, LAT=2 -> busy for 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once.
REQ-035 MULTU with a=0xFFFFFFFF, b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, done pulse after each, busy never high.
REQ-037 With MUL_HILO_MADD_EN, hi=0, lo=0xFFFFFFFF, then MADDU a=1, b=1 -> hi=0x00000001, lo=0x00000000; without the macro, the same stimulus leaves hi and lo unchanged and done low.
REQ-038 MULT accepted, then start with MTLO on the next cycle -> MTLO ignored, and only the product is written.
REQ-039 rst driven low one cycle after a MULT is accepted -> hi=0, lo=0, busy=0, and no done pulse after release.
